logic_shift_unit: RTL and testbench
===================================

LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (legal: power of two, 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  request pulse; operands and op are sampled when start=1 and busy=0.
REQ-006 SHALL have port aluOp  input  4  operation code (see REQ-012).
REQ-007 SHALL have port A  input  WIDTH  first operand (shift source for shift ops).
REQ-008 SHALL have port B  input  WIDTH  second operand (LUI immediate source).
REQ-009 SHALL have port shamt  input  SHAMT_W  shift amount.
REQ-010 SHALL have port Result  output  WIDTH  registered result, held stable until next accepted start.
REQ-011 SHALL have ports busy  output  1  (operation in flight); done  output  1  (one-cycle completion pulse); zero  output  1  (Result==0, valid with done); illegal  output  1  (unsupported aluOp, valid with done).

Function
REQ-012 SHALL decode aluOp: 0100 AND, 0101 OR, 0110 XOR, 0111 NOR, 1000 SLL, 1001 SRL, 1010 SRA, 1011 LUI (B[WIDTH/2-1:0] placed in upper half, lower half zero); all other codes illegal.
REQ-013 SHALL implement FSM states IDLE, SHIFT, FINISH; reset state IDLE.
REQ-014 IDLE: on accepted start with logical op, LUI or illegal op -> compute result, go FINISH (Result and done visible 1 cycle after start; latency 1).
REQ-015 IDLE: on accepted start with shift op and shamt!=0 -> load A into working register, load shamt into down-counter, go SHIFT; shamt==0 -> Result=A, go FINISH (latency 1).
REQ-016 SHIFT: each cycle shift working register one bit (SLL zero-fill LSB, SRL zero-fill MSB, SRA replicate MSB) and decrement counter; when counter reaches 1 the final shift is applied and state -> FINISH; total latency shamt+1 cycles start-to-done.
REQ-017 FINISH: assert done for exactly one cycle, update zero/illegal, return to IDLE next cycle.
REQ-018 busy SHALL be 1 in SHIFT and FINISH, 0 in IDLE; start while busy=1 SHALL be ignored with no state change.
REQ-019 Illegal op SHALL give Result=0, illegal=1, zero=1 at done.
REQ-020 Operand changes on A, B, aluOp, shamt after acceptance SHALL NOT affect the in-flight operation.
REQ-021 shamt values >= WIDTH are impossible by width; max shamt WIDTH-1 gives latency WIDTH cycles.
REQ-022 Back-to-back: start asserted in the cycle after done (state IDLE) SHALL be accepted.

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, Result=0, busy=0, done=0, zero=0, illegal=0, counter=0.
REQ-024 Reset mid-SHIFT SHALL abort the operation with no done pulse; first start after rst_n deasserts is accepted normally.

Structure
REQ-025 aluOp encodings and FSM state encoding SHALL live in shared package alu_pkg, reusable by the multi-cycle ALU top.
REQ-026 Single-cycle AND/OR/XOR/NOR/LUI decode SHALL be a sub-module logic_core (combinational, WIDTH-parametrised); FSM, counter and shifter stay in logic_shift_unit.

Verification
REQ-027 WIDTH=32: start, aluOp=0110, A=0xF0F0_F0F0, B=0xFFFF_0000 -> done 1 cycle later, Result=0x0F0F_F0F0, zero=0.
REQ-028 WIDTH=32: start, aluOp=1010 (SRA), A=0x8000_0000, shamt=4 -> busy 5 cycles, done on cycle 5, Result=0xF800_0000.
REQ-029 WIDTH=32: SLL A=0x1, shamt=31 -> done after 32 cycles, Result=0x8000_0000; second start pulsed during busy is ignored.
REQ-030 WIDTH=32: aluOp=0111 (NOR) A=0xFFFF_FFFF, B=0 -> Result=0, zero=1; aluOp=1111 -> Result=0, illegal=1.
REQ-031 WIDTH=32: SRL shamt=10 started, rst_n low at cycle 3 -> outputs zero immediately, no done; subsequent LUI B=0x0000_1234 -> Result=0x1234_0000.
REQ-032 WIDTH=8: SRA A=0x90, shamt=3 -> Result=0xF2 after 4 cycles; shamt=0 -> Result=A after 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: operation codes and FSM state encoding for the ALU family
// (logic/shift unit now, multi-cycle ALU top later).
//   alu_op_e   - 4-bit aluOp encodings
//   state_e    - sequencing states of the multi-cycle units
//   is_shift_op - true for SLL/SRL/SRA
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101,
    OP_XOR = 4'b0110,
    OP_NOR = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_LUI = 4'b1011
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/logic_core.sv
// logic_core: single-cycle bitwise/LUI datapath.
//   i_op     - aluOp code
//   i_a      - first operand
//   i_b      - second operand (LUI immediate in lower half)
//   o_result - AND/OR/XOR/NOR/LUI result, zero for any other code
//   o_valid  - 1 when i_op is one of the codes handled here
module logic_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_valid
);

  always_comb begin
    o_result = '0;
    o_valid  = 1'b1;
    case (i_op)
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_LUI:  o_result = {i_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      default: o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/logic_shift_unit.sv
// logic_shift_unit: logic ops and LUI in one cycle, shifts one bit per
// cycle through a down-counter.
//   clk, rst_n - clock, async active-low reset
//   start      - request, taken only while busy=0
//   aluOp      - operation code (alu_pkg::alu_op_e)
//   A, B       - operands; shamt - shift amount
//   Result     - registered result, held until next completion
//   busy       - operation in flight (SHIFT or FINISH)
//   done       - one-cycle completion pulse
//   zero       - Result==0, valid with done
//   illegal    - aluOp unsupported, valid with done
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | shifting working register one bit per cycle
// FINISH | done pulse cycle, returns to IDLE
module logic_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [3:0]         aluOp,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   Result,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic               illegal
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_work;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_op;

  logic [WIDTH-1:0]   w_core_result;
  logic               w_core_valid;
  logic [WIDTH-1:0]   w_shift_next;

  logic_core #(.WIDTH(WIDTH)) u_core (
    .i_op    (aluOp),
    .i_a     (A),
    .i_b     (B),
    .o_result(w_core_result),
    .o_valid (w_core_valid)
  );

  // r_op only ever holds a shift code while in SHIFT
  always_comb begin
    w_shift_next = r_work;
    case (r_op)
      OP_SLL:  w_shift_next = {r_work[WIDTH-2:0], 1'b0};
      OP_SRL:  w_shift_next = {1'b0, r_work[WIDTH-1:1]};
      default: w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_op    <= '0;
      Result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      zero    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (is_shift_op(aluOp) && (shamt != '0)) begin
              r_work  <= A;
              r_cnt   <= shamt;
              r_op    <= aluOp;
              r_state <= ST_SHIFT;
            end else if (is_shift_op(aluOp)) begin
              Result  <= A;
              zero    <= (A == '0);
              illegal <= 1'b0;
              done    <= 1'b1;
              r_state <= ST_FINISH;
            end else begin
              // core returns zero for unsupported codes
              Result  <= w_core_result;
              zero    <= (w_core_result == '0);
              illegal <= ~w_core_valid;
              done    <= 1'b1;
              r_state <= ST_FINISH;
            end
          end
        end
        ST_SHIFT: begin
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == SHAMT_W'(1)) begin
            Result  <= w_shift_next;
            zero    <= (w_shift_next == '0);
            illegal <= 1'b0;
            done    <= 1'b1;
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_shift_unit.sv
module tb_logic_shift_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start32 = 1'b0;
  logic [3:0]  op32 = '0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [4:0]  sh32 = '0;
  logic [31:0] res32;
  logic        busy32, done32, zero32, ill32;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [2:0]  sh8 = '0;
  logic [7:0]  res8;
  logic        busy8, done8, zero8, ill8;

  logic_shift_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .aluOp(op32), .A(a32), .B(b32),
    .shamt(sh32), .Result(res32), .busy(busy32), .done(done32), .zero(zero32),
    .illegal(ill32)
  );

  logic_shift_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .aluOp(op8), .A(a8), .B(b8),
    .shamt(sh8), .Result(res8), .busy(busy8), .done(done8), .zero(zero8),
    .illegal(ill8)
  );

  typedef struct {
    logic [63:0] r;
    logic        z;
    logic        i;
    int          lat;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference for width w (32 or 8)
  function automatic logic [63:0] model(input int w, input logic [3:0] op,
                                        input logic [63:0] a_in, input logic [63:0] b_in,
                                        input int sh);
    logic [63:0] m, a, b, sa, r;
    m = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
    a = a_in & m;
    b = b_in & m;
    sa = a[w-1] ? (a | ~m) : a;
    case (op)
      4'h4: r = a & b;
      4'h5: r = a | b;
      4'h6: r = a ^ b;
      4'h7: r = ~(a | b);
      4'h8: r = a << sh;
      4'h9: r = a >> sh;
      4'hA: r = $signed(sa) >>> sh;
      4'hB: r = (b & (m >> (w / 2))) << (w / 2);
      default: r = '0;
    endcase
    return r & m;
  endfunction

  task automatic drive(input bit w8, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input int sh, input bit st);
    if (w8) begin
      start8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; sh8 = 3'(sh);
    end else begin
      start32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0]; sh32 = 5'(sh);
    end
  endtask

  // Called at a negedge with the selected unit idle. Pushes the expectation,
  // issues start, scrambles operands after acceptance, optionally pulses a
  // second start at cycle inject_at, then pops and checks at done.
  task automatic run_op(input string tag, input bit w8, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b, input int sh,
                        input logic [63:0] exp_r, input int inject_at);
    exp_t e;
    int cyc;
    bit seen;
    e.r = exp_r;
    e.z = (exp_r == 64'd0);
    e.i = !(op inside {[4'h4:4'hB]});
    e.lat = ((op inside {4'h8, 4'h9, 4'hA}) && sh != 0) ? sh + 1 : 1;
    q.push_back(e);
    drive(w8, op, a, b, sh, 1'b1);
    @(negedge clk);
    drive(w8, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(0, 7)), 1'b0);
    cyc = 1;
    seen = w8 ? done8 : done32;
    while (!seen && cyc < 80) begin
      if (cyc == inject_at) drive(w8, 4'h4, 64'hFFFF, 64'hFFFF, 0, 1'b1);
      @(negedge clk);
      if (w8) start8 = 1'b0; else start32 = 1'b0;
      cyc++;
      seen = w8 ? done8 : done32;
    end
    e = q.pop_front();
    check({tag, "/done_seen"}, 64'(seen), 64'd1);
    check({tag, "/latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "/result"}, w8 ? {56'd0, res8} : {32'd0, res32}, e.r);
    check({tag, "/zero"}, 64'(w8 ? zero8 : zero32), 64'(e.z));
    check({tag, "/illegal"}, 64'(w8 ? ill8 : ill32), 64'(e.i));
    check({tag, "/busy_at_done"}, 64'(w8 ? busy8 : busy32), 64'd1);
    @(negedge clk);
    check({tag, "/done_cleared"}, 64'(w8 ? done8 : done32), 64'd0);
    check({tag, "/idle_after"}, 64'(w8 ? busy8 : busy32), 64'd0);
  endtask

  initial begin
    int pulses;
    logic [3:0] rop;
    logic [63:0] ra, rb;
    int rsh;

    repeat (2) @(negedge clk);
    check("rst/result32", {32'd0, res32}, 64'd0);
    check("rst/busy32", 64'(busy32), 64'd0);
    check("rst/done32", 64'(done32), 64'd0);
    check("rst/zero32", 64'(zero32), 64'd0);
    check("rst/illegal32", 64'(ill32), 64'd0);
    check("rst/result8", {56'd0, res8}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("xor", 1'b0, 4'b0110, 64'hF0F0_F0F0, 64'hFFFF_0000, 0, 64'h0F0F_F0F0, -1);
    run_op("sra4", 1'b0, 4'b1010, 64'h8000_0000, 64'h0, 4, 64'hF800_0000, -1);
    run_op("sll31", 1'b0, 4'b1000, 64'h1, 64'h0, 31, 64'h8000_0000, 5);
    run_op("nor", 1'b0, 4'b0111, 64'hFFFF_FFFF, 64'h0, 0, 64'h0, -1);
    run_op("illegal", 1'b0, 4'b1111, 64'h1234_5678, 64'h9ABC_DEF0, 3, 64'h0, -1);

    drive(1'b0, 4'b1001, 64'hFFFF_0000, 64'h0, 10, 1'b1);
    @(negedge clk);
    start32 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort/result", {32'd0, res32}, 64'd0);
    check("abort/busy", 64'(busy32), 64'd0);
    check("abort/done", 64'(done32), 64'd0);
    check("abort/zero", 64'(zero32), 64'd0);
    check("abort/illegal", 64'(ill32), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check("abort/no_done", 64'(pulses), 64'd0);
    run_op("lui", 1'b0, 4'b1011, 64'h0, 64'h0000_1234, 0, 64'h1234_0000, -1);

    run_op("w8_sra3", 1'b1, 4'b1010, 64'h90, 64'h0, 3, 64'hF2, -1);
    run_op("w8_sra0", 1'b1, 4'b1010, 64'h90, 64'h0, 0, 64'h90, -1);
    run_op("w8_srl7", 1'b1, 4'b1001, 64'hFF, 64'h0, 7, 64'h01, -1);
    run_op("w8_lui", 1'b1, 4'b1011, 64'h0, 64'hA5, 0, 64'h50, -1);

    for (int k = 0; k < 8; k++) begin
      rop = 4'($urandom_range(4, 11));
      ra = {32'd0, $urandom};
      rb = {32'd0, $urandom};
      rsh = int'($urandom_range(0, 9));
      run_op($sformatf("rnd32_%0d", k), 1'b0, rop, ra, rb, rsh, model(32, rop, ra, rb, rsh), -1);
    end
    for (int k = 0; k < 6; k++) begin
      rop = 4'($urandom_range(0, 15));
      ra = {56'd0, 8'($urandom)};
      rb = {56'd0, 8'($urandom)};
      rsh = int'($urandom_range(0, 7));
      run_op($sformatf("rnd8_%0d", k), 1'b1, rop, ra, rb, rsh, model(8, rop, ra, rb, rsh), -1);
    end

    check("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
